muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit between the register-file read ports and the write-back port of the core. It takes rs1/rs2 operand values and the destination index, computes one of the eight RV32M operations, and presents the result with a one-cycle write strobe that drives the register-file write port (WE3/A3/WD3). While it is busy, the core stalls on `busy`.

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_sign_cond.sv | 41 ++++
 rtl/muldiv_unit.sv | 191 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared RV32M definitions: opcodes, FSM encoding and the divide special-case constants.
package muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] DIV_ZERO_RES = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] OVF_DIVIDEND = 32'h8000_0000;
  localparam logic [XLEN-1:0] OVF_DIVISOR  = 32'hFFFF_FFFF;

  // DIV and REM are the signed divide opcodes.
  function automatic logic is_signed_div(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_sign_cond.sv
// Operand magnitude / negate-flag generation and conditional negate of the final product.
module muldiv_sign_cond
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [2:0]              funct3,
  input  logic [DATA_WIDTH-1:0]   op_a,
  input  logic [DATA_WIDTH-1:0]   op_b,
  output logic [DATA_WIDTH-1:0]   mag_a_c,
  output logic [DATA_WIDTH-1:0]   mag_b_c,
  output logic                    neg_c,
  input  logic                    neg_en,
  input  logic [2*DATA_WIDTH-1:0] raw,
  output logic [2*DATA_WIDTH-1:0] cond_c
);

  localparam int unsigned DW = DATA_WIDTH;

  logic sgn_a_en;
  logic sgn_b_en;
  logic neg_a;
  logic neg_b;

  always_comb begin
    sgn_a_en = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) || is_signed_div(funct3);
    sgn_b_en = (funct3 == F3_MULH) || is_signed_div(funct3);
    neg_a    = sgn_a_en && op_a[DW-1];
    neg_b    = sgn_b_en && op_b[DW-1];
    mag_a_c  = neg_a ? (~op_a + DW'(1)) : op_a;
    mag_b_c  = neg_b ? (~op_b + DW'(1)) : op_b;
    // Remainder follows the dividend; product and quotient follow the sign XOR.
    unique case (funct3)
      F3_MULH, F3_DIV: neg_c = neg_a ^ neg_b;
      F3_MULHSU, F3_REM: neg_c = neg_a;
      default: neg_c = 1'b0;
    endcase
    cond_c = neg_en ? (~raw + (2*DW)'(1)) : raw;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-divide steps per operation.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned ADDRESS_BIT_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         start,
  input  logic [2:0]                   funct3,
  input  logic [DATA_WIDTH-1:0]        op_a,
  input  logic [DATA_WIDTH-1:0]        op_b,
  input  logic [ADDRESS_BIT_WIDTH-1:0] rd_in,
  output logic                         busy,
  output logic                         done,
  output logic                         we_out,
  output logic [ADDRESS_BIT_WIDTH-1:0] rd_out,
  output logic [DATA_WIDTH-1:0]        result
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned AW = ADDRESS_BIT_WIDTH;
  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_WIDTH - 1);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [DW-1:0]   opa_q, opa_d;
  logic [DW-1:0]   opb_q, opb_d;
  logic [2:0]      f3_q, f3_d;
  logic            neg_q, neg_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [DW-1:0]   result_q, result_d;
  logic            done_q, done_d;
  logic            we_q, we_d;
  logic            busy_q, busy_d;

  logic [DW-1:0]   mag_a_c, mag_b_c;
  logic            neg_c;
  logic [PW-1:0]   fin_raw_c, fin_cond_c;
  logic            special_c;
  logic [DW-1:0]   special_res_c;
  logic [PW-1:0]   mul_acc_c;
  logic [DW:0]     rem_sh_c, diff_c;
  logic            q_bit_c;
  logic [DW-1:0]   div_rem_c, div_quo_c;
  logic [DW-1:0]   fin_sel_c;

  muldiv_sign_cond #(.DATA_WIDTH(DW)) u_sign_cond (
    .funct3  (funct3),
    .op_a    (op_a),
    .op_b    (op_b),
    .mag_a_c (mag_a_c),
    .mag_b_c (mag_b_c),
    .neg_c   (neg_c),
    .neg_en  (neg_q),
    .raw     (fin_raw_c),
    .cond_c  (fin_cond_c)
  );

  // Divide-by-zero and signed overflow complete without iterating.
  always_comb begin
    special_c     = 1'b0;
    special_res_c = '0;
    if (funct3[2]) begin
      if (op_b == '0) begin
        special_c     = 1'b1;
        special_res_c = funct3[1] ? op_a : DW'(DIV_ZERO_RES);
      end else if (is_signed_div(funct3) && (op_a == DW'(OVF_DIVIDEND)) &&
                   (op_b == DW'(OVF_DIVISOR))) begin
        special_c     = 1'b1;
        special_res_c = funct3[1] ? '0 : DW'(OVF_DIVIDEND);
      end
    end
  end

  // One iteration of each datapath; acc is the product or, in its low word, the remainder.
  always_comb begin
    mul_acc_c = acc_q + (opb_q[cnt_q] ? (PW'(opa_q) << cnt_q) : '0);
    rem_sh_c  = {acc_q[DW-1:0], opa_q[DW-1]};
    diff_c    = rem_sh_c - {1'b0, opb_q};
    q_bit_c   = ~diff_c[DW];
    div_rem_c = q_bit_c ? diff_c[DW-1:0] : rem_sh_c[DW-1:0];
    div_quo_c = {opa_q[DW-2:0], q_bit_c};
    if (f3_q[2]) begin
      fin_raw_c = f3_q[1] ? PW'(div_rem_c) : PW'(div_quo_c);
    end else begin
      fin_raw_c = mul_acc_c;
    end
    if ((f3_q == F3_MUL) || f3_q[2]) begin
      fin_sel_c = fin_cond_c[DW-1:0];
    end else begin
      fin_sel_c = fin_cond_c[PW-1:DW];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    rd_d     = rd_q;
    result_d = result_q;
    done_d   = done_q;
    we_d     = we_q;
    busy_d   = busy_q;
    if (en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            f3_d  = funct3;
            rd_d  = rd_in;
            acc_d = '0;
            cnt_d = '0;
            if (special_c) begin
              result_d = special_res_c;
              neg_d    = 1'b0;
              state_d  = ST_DONE;
            end else begin
              opa_d   = mag_a_c;
              opb_d   = mag_b_c;
              neg_d   = neg_c;
              state_d = ST_CALC;
            end
          end
        end
        ST_CALC: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (f3_q[2]) begin
            acc_d = PW'(div_rem_c);
            opa_d = div_quo_c;
          end else begin
            acc_d = mul_acc_c;
          end
          if (cnt_q == LAST_STEP) begin
            result_d = fin_sel_c;
            state_d  = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
      done_d = (state_d == ST_DONE);
      we_d   = done_d && (rd_d != '0);
      busy_d = (state_d != ST_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      done_q   <= done_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign we_out = we_q;
  assign rd_out = rd_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: reference RV32M model, latency and strobe checks.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        en;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic        we_out;
  logic [4:0]  rd_out;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          accept;
    int          lat;
  } exp_t;

  exp_t scb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic en_edge = 1'b1;
  logic prev_done = 1'b0;

  muldiv_unit #(.DATA_WIDTH(32), .ADDRESS_BIT_WIDTH(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .we_out (we_out),
    .rd_out (rd_out),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    en_edge <= en;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 1'b0;
    if (b == 32'h0) return 1'b1;
    return (f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sbv;
    longint ub;
    logic [63:0] p;
    int ia;
    int ib;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ub  = longint'({32'h0, b});
    ia  = $signed(a);
    ib  = $signed(b);
    case (f3)
      3'd0: begin p = 64'(sa * sbv); return p[31:0]; end
      3'd1: begin p = 64'(sa * sbv); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Outputs are sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (prev_done) begin
        check_eq("done_single_cycle", {63'h0, en_edge}, 64'h0);
      end else if (scb.size() == 0) begin
        check_eq("spurious_done", 64'h1, 64'h0);
      end else begin
        e = scb.pop_front();
        check_eq("result", {32'h0, result}, {32'h0, e.res});
        check_eq("rd_out", {59'h0, rd_out}, {59'h0, e.rd});
        check_eq("we_out", {63'h0, we_out}, {63'h0, (e.rd != 5'd0)});
        check_eq("busy_in_done", {63'h0, busy}, 64'h1);
        check_eq("latency", 64'(cyc - e.accept), 64'(e.lat));
      end
    end
    prev_done <= done;
  end

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    if (busy) check_eq("idle_timeout", 64'h1, 64'h0);
  endtask

  task automatic drive_start(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd);
    start  = 1'b1;
    funct3 = f3;
    op_a   = a;
    op_b   = b;
    rd_in  = rd;
    @(negedge clk);
    start  = 1'b0;
    op_a   = $urandom;
    op_b   = $urandom;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int extra);
    exp_t e;
    wait_idle();
    e.res    = model(f3, a, b);
    e.rd     = rd;
    e.accept = cyc + 1;
    e.lat    = is_special(f3, a, b) ? 0 : 32 + extra;
    scb.push_back(e);
    drive_start(f3, a, b, rd);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (scb.size() != 0 || busy); i++) @(negedge clk);
    if (scb.size() != 0 || busy) check_eq("drain_timeout", 64'h1, 64'h0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; start = 1'b0;
    funct3 = 3'd0; op_a = 32'h0; op_b = 32'h0; rd_in = 5'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy",   {63'h0, busy},   64'h0);
    check_eq("rst_done",   {63'h0, done},   64'h0);
    check_eq("rst_we",     {63'h0, we_out}, 64'h0);
    check_eq("rst_rd",     {59'h0, rd_out}, 64'h0);
    check_eq("rst_result", {32'h0, result}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 0);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 0);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 0);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 0);
    issue(3'd5, 32'd100, 32'd7, 5'd7, 0);
    issue(3'd7, 32'd100, 32'd7, 5'd8, 0);
    issue(3'd5, 32'd5, 32'd0, 5'd9, 0);
    issue(3'd6, 32'd5, 32'd0, 5'd10, 0);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0);
    issue(3'd1, 32'h1234_5678, 32'hFEDC_BA98, 5'd13, 0);
    issue(3'd4, 32'd0, 32'h8000_0000, 5'd14, 0);
    issue(3'd0, 32'd9, 32'd9, 5'd0, 0);
    drain();

    // Reset mid-iteration discards the operation.
    wait_idle();
    drive_start(3'd4, 32'hFFFF_FF9C, 32'd7, 5'd15);
    repeat (9) @(negedge clk);
    check_eq("busy_mid_calc", {63'h0, busy}, 64'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_mid_busy",   {63'h0, busy},   64'h0);
    check_eq("rst_mid_done",   {63'h0, done},   64'h0);
    check_eq("rst_mid_result", {32'h0, result}, 64'h0);
    issue(3'd0, 32'd3, 32'd4, 5'd16, 0);
    drain();

    // A start pulse while busy must not be accepted or queued.
    issue(3'd0, 32'd1000, 32'd1000, 5'd17, 0);
    repeat (5) @(negedge clk);
    drive_start(3'd5, 32'd9, 32'd3, 5'd18);
    drain();

    // Enable dropped for 5 edges mid-CALC stretches latency by exactly 5.
    issue(3'd4, 32'hFFFF_FC18, 32'd33, 5'd19, 5);
    repeat (7) @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("busy_en_low", {63'h0, busy}, 64'h1);
    en = 1'b1;
    drain();

    for (int i = 0; i < 8; i++) begin
      issue(3'($urandom_range(0, 7)), $urandom, (i == 3) ? 32'h0 : $urandom, 5'($urandom_range(0, 31)), 0);
    end
    drain();
    check_eq("scoreboard_empty", 64'(scb.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1);
  end

endmodule
